pwm_fade_scheduler: RTL and testbench

PWM_FADE_SCHEDULER -- requirements
Module: pwm_fade_scheduler

---
 rtl/pwm_fade_scheduler.sv | 112 +++++++++++
 tb/tb_pwm_fade_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_scheduler.sv
// Three-channel LED PWM generator with per-channel linear fades.
// Each channel ramps its duty level one step per (rate+1) PWM periods toward a commanded target.
module pwm_fade_scheduler #(
   parameter int COUNTER_BITS = 8,
   parameter int NCHAN        = 3
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_chan,
   input  logic [COUNTER_BITS-1:0] cmd_target,
   input  logic [7:0]              cmd_rate,
   output logic [NCHAN-1:0]        led,
   output logic [NCHAN-1:0]        busy,
   output logic [NCHAN-1:0]        done,
   output logic                    cmd_err
);

   typedef enum logic {IDLE, RAMP} state_t;

   localparam logic [COUNTER_BITS-1:0] CNT_MAX = '1;
   localparam logic [COUNTER_BITS-1:0] CNT_ONE = {{(COUNTER_BITS-1){1'b0}}, 1'b1};

   logic [COUNTER_BITS-1:0] counter_reg;
   logic                    ready_pre_reg;
   logic                    ready_reg;
   logic                    err_reg;
   logic                    period_tick;
   logic                    accept;

   assign period_tick = (counter_reg == CNT_MAX);
   assign accept      = cmd_valid && ready_reg;
   assign cmd_ready   = ready_reg;
   assign cmd_err     = err_reg;

   // Ready comes up through two flops so the first full cycle after release refuses commands.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         counter_reg   <= '0;
         ready_pre_reg <= 1'b0;
         ready_reg     <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         counter_reg   <= counter_reg + CNT_ONE;
         ready_pre_reg <= 1'b1;
         ready_reg     <= ready_pre_reg;
         err_reg       <= accept && (cmd_chan == 2'd3);
      end
   end

   generate
      for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
         state_t                  state_reg;
         logic [COUNTER_BITS-1:0] level_reg;
         logic [COUNTER_BITS-1:0] target_reg;
         logic [COUNTER_BITS-1:0] level_step;
         logic [7:0]              rate_reg;
         logic [7:0]              rate_cnt_reg;
         logic                    led_reg;
         logic                    done_reg;
         logic                    hit;

         assign hit        = accept && (cmd_chan == 2'(gi));
         // Only meaningful while ramping, where level never equals target.
         assign level_step = (target_reg > level_reg) ? level_reg + CNT_ONE
                                                      : level_reg - CNT_ONE;

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               state_reg    <= IDLE;
               level_reg    <= '0;
               target_reg   <= '0;
               rate_reg     <= '0;
               rate_cnt_reg <= '0;
               led_reg      <= 1'b0;
               done_reg     <= 1'b0;
            end else begin
               led_reg  <= (counter_reg < level_reg);
               done_reg <= 1'b0;
               if (hit) begin
                  target_reg   <= cmd_target;
                  rate_reg     <= cmd_rate;
                  rate_cnt_reg <= '0;
                  if (cmd_target != level_reg) begin
                     state_reg <= RAMP;
                  end else begin
                     state_reg <= IDLE;
                     done_reg  <= 1'b1;
                  end
               end else if (state_reg == RAMP && period_tick) begin
                  if (rate_cnt_reg == rate_reg) begin
                     level_reg    <= level_step;
                     rate_cnt_reg <= '0;
                     if (level_step == target_reg) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                     end
                  end else begin
                     rate_cnt_reg <= rate_cnt_reg + 8'd1;
                  end
               end
            end
         end

         assign led[gi]  = led_reg;
         assign busy[gi] = (state_reg == RAMP);
         assign done[gi] = done_reg;
      end
   endgenerate

endmodule

// File: tb/tb_pwm_fade_scheduler.sv
// Bench for pwm_fade_scheduler at COUNTER_BITS = 4: directed fade scenarios plus random commands,
// checked against a cycle-level reference model with a queue of expected done/cmd_err pulses.
module tb_pwm_fade_scheduler;

   logic       clk = 1'b0;
   logic       resetn;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_chan;
   logic [3:0] cmd_target;
   logic [7:0] cmd_rate;
   logic [2:0] led;
   logic [2:0] busy;
   logic [2:0] done;
   logic       cmd_err;

   pwm_fade_scheduler #(.COUNTER_BITS(4), .NCHAN(3)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_chan   (cmd_chan),
      .cmd_target (cmd_target),
      .cmd_rate   (cmd_rate),
      .led        (led),
      .busy       (busy),
      .done       (done),
      .cmd_err    (cmd_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: duty levels as integers, stepping toward target once every rate+1 periods.
   typedef struct {int cyc; int chan;} ev_t;
   ev_t q[$];

   int   m_cnt, m_rel, m_edge;
   int   m_level[3], m_target[3], m_rate[3], m_wait[3];
   bit   m_ramp[3];
   bit   tick_b, acc_b;
   logic [2:0] exp_led, exp_busy;
   logic [3:0] exp_ev;
   ev_t  new_ev;

   initial m_edge = 0;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_cnt = 0;
         m_rel = 0;
         for (int c = 0; c < 3; c++) begin
            m_level[c] = 0; m_target[c] = 0; m_rate[c] = 0; m_wait[c] = 0; m_ramp[c] = 0;
         end
         exp_led  = 3'b000;
         exp_busy = 3'b000;
         q.delete();
      end else begin
         m_edge++;
         tick_b = (m_cnt == 15);
         acc_b  = cmd_valid && (m_rel >= 2);
         exp_ev = 4'b0000;
         for (int c = 0; c < 3; c++) begin
            exp_led[c] = (m_cnt < m_level[c]);
            if (acc_b && int'(cmd_chan) == c) begin
               m_target[c] = int'(cmd_target);
               m_rate[c]   = int'(cmd_rate);
               m_wait[c]   = 0;
               m_ramp[c]   = (m_target[c] != m_level[c]);
               if (!m_ramp[c]) exp_ev[c] = 1'b1;
            end else if (m_ramp[c] && tick_b) begin
               if (m_wait[c] >= m_rate[c]) begin
                  m_level[c] += (m_target[c] > m_level[c]) ? 1 : -1;
                  m_wait[c] = 0;
                  if (m_level[c] == m_target[c]) begin
                     m_ramp[c] = 0;
                     exp_ev[c] = 1'b1;
                  end
               end else begin
                  m_wait[c]++;
               end
            end
            exp_busy[c] = m_ramp[c];
         end
         if (acc_b && cmd_chan == 2'd3) exp_ev[3] = 1'b1;
         for (int c = 0; c < 4; c++) begin
            if (exp_ev[c]) begin
               new_ev.cyc  = m_edge;
               new_ev.chan = c;
               q.push_back(new_ev);
            end
         end
         m_cnt = (m_cnt + 1) % 16;
         if (m_rel < 2) m_rel++;
      end
   end

   // Monitor: per-cycle led/busy/ready, and pulses matched against the expected-event queue.
   ev_t got_ev;
   always @(negedge clk) begin
      if (resetn) begin
         chk("led", int'(led), int'(exp_led));
         chk("busy", int'(busy), int'(exp_busy));
         chk("cmd_ready", int'(cmd_ready), (m_rel >= 2) ? 1 : 0);
         for (int c = 0; c < 4; c++) begin
            if ((c < 3) ? done[c] : cmd_err) begin
               if (q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_pulse: got pulse on chan %0d expected none (t=%0t)", c, $time);
               end else begin
                  got_ev = q.pop_front();
                  chk("pulse_chan", c, got_ev.chan);
                  chk("pulse_cycle", m_edge, got_ev.cyc);
               end
            end
         end
         while (q.size() > 0 && q[0].cyc <= m_edge) begin
            n_checks++;
            n_errors++;
            $display("FAIL missed_pulse: got none expected pulse on chan %0d at edge %0d (t=%0t)",
                     q[0].chan, q[0].cyc, $time);
            void'(q.pop_front());
         end
      end
   end

   // Caller is at a negedge; the command is accepted on the following posedge.
   task automatic send(input int ch, input int tgt, input int rate);
      cmd_valid  = 1'b1;
      cmd_chan   = 2'(ch);
      cmd_target = 4'(tgt);
      cmd_rate   = 8'(rate);
      $display("cmd chan=%0d target=%0d rate=%0d t=%0t", ch, tgt, rate, $time);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int ch, input int bound);
      int n = 0;
      while (!done[ch] && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("done%0d_seen", ch), int'(done[ch]), 1);
      @(negedge clk);
   endtask

   task automatic release_and_check_ready();
      #3 resetn = 1'b1;
      @(negedge clk);
      chk("ready_after_1_edge", int'(cmd_ready), 0);
      @(negedge clk);
      chk("ready_after_2_edges", int'(cmd_ready), 1);
   endtask

   initial begin
      int n;
      resetn     = 1'b0;
      cmd_valid  = 1'b0;
      cmd_chan   = 2'd0;
      cmd_target = 4'd0;
      cmd_rate   = 8'd0;
      repeat (3) @(negedge clk);
      chk("reset_led", int'(led), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_ready", int'(cmd_ready), 0);
      release_and_check_ready();

      // Basic fade up on ch0, then steady 3/16 duty.
      send(0, 3, 0);
      chk("busy0_after_cmd", int'(busy[0]), 1);
      wait_done(0, 100);
      repeat (40) @(negedge clk);

      // Slow fade on ch1: one step per three periods.
      send(1, 2, 2);
      wait_done(1, 200);

      // Retarget ch2 mid-ramp, reversing direction at level 5.
      send(2, 15, 0);
      n = 0;
      while (m_level[2] != 5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("ch2_reached_5", m_level[2], 5);
      send(2, 1, 0);
      wait_done(2, 200);

      // Target equal to current level, and an invalid channel.
      send(0, 3, 5);
      chk("busy0_same_level", int'(busy[0]), 0);
      chk("done0_same_level", int'(done[0]), 1);
      send(3, 7, 1);
      chk("cmd_err_pulse", int'(cmd_err), 1);
      chk("busy_after_err", int'(busy), 0);

      // Command landing on the period_tick cycle, then simultaneous completion of ch1 and ch2.
      while (m_cnt != 15) @(negedge clk);
      send(0, 8, 0);
      while (m_cnt != 2) @(negedge clk);
      send(1, 4, 0);
      send(2, 3, 0);
      n = 0;
      while (done == 3'b000 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("done_simultaneous", int'(done), 3'b110);
      wait_done(0, 200);

      // Random command traffic including retargets and invalid channels.
      for (int i = 0; i < 40; i++) begin
         send($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 3));
         repeat ($urandom_range(0, 40)) @(negedge clk);
      end

      // Asynchronous reset in the middle of a ramp.
      @(negedge clk);
      send(1, 15, 3);
      repeat (20) @(negedge clk);
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("async_led", int'(led), 0);
      chk("async_busy", int'(busy), 0);
      chk("async_done", int'(done), 0);
      chk("async_ready", int'(cmd_ready), 0);
      repeat (2) @(negedge clk);
      release_and_check_ready();
      repeat (40) @(negedge clk);
      chk("busy_after_reset", int'(busy), 0);
      send(2, 2, 1);
      wait_done(2, 200);

      // Drain any remaining ramps before finishing.
      n = 0;
      while ((busy != 3'b000 || q.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_busy", int'(busy), 0);
      chk("drain_queue", q.size(), 0);
      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
